// File: rtl/exu_wbck_arb_pkg.sv
// Shared parameters and types for the EXU write-back arbiter.
package exu_wbck_arb_pkg;

    // Default datapath widths for the core's register file write port.
    localparam int XLEN            = 32;
    localparam int RFIDX_WIDTH     = 5;

    // Default number of consecutive LSU grants tolerated while the ALU waits.
    localparam int WBCK_STARVE_MAX = 4;

    // Which requester owns the write port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LSU  = 2'd2
    } wbck_gnt_e;

    // Width of a counter that must represent 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/exu_wbck_arb.sv
// Write-back arbiter: shares the register file write port between the
// single-cycle ALU and the multi-cycle LSU. The LSU has fixed priority, but
// after STARVE_MAX consecutive LSU grants with the ALU waiting, the ALU is
// forced through. The write reaches the register file one cycle after grant.
module exu_wbck_arb
    import exu_wbck_arb_pkg::*;
#(
    parameter int XLEN_P        = XLEN,
    parameter int RFIDX_WIDTH_P = RFIDX_WIDTH,
    parameter int STARVE_MAX    = WBCK_STARVE_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_wbck_i_valid,
    output logic                     alu_wbck_i_ready,
    input  logic [XLEN_P-1:0]        alu_wbck_i_wdat,
    input  logic [RFIDX_WIDTH_P-1:0] alu_wbck_i_rdidx,
    input  logic                     lsu_wbck_i_valid,
    output logic                     lsu_wbck_i_ready,
    input  logic [XLEN_P-1:0]        lsu_wbck_i_wdat,
    input  logic [RFIDX_WIDTH_P-1:0] lsu_wbck_i_rdidx,
    output logic                     rf_wbck_o_ena,
    output logic [XLEN_P-1:0]        rf_wbck_o_wdat,
    output logic [RFIDX_WIDTH_P-1:0] rf_wbck_o_rdidx,
    output logic                     wbck_idle
);

    localparam int              CNT_W        = cnt_width(STARVE_MAX);
    localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);

    // x0 is hard-wired zero: a write to it is accepted but never enabled.
    function automatic logic is_rf_write(input logic [RFIDX_WIDTH_P-1:0] idx);
        return (idx != {RFIDX_WIDTH_P{1'b0}});
    endfunction

    logic [CNT_W-1:0]         starve_cnt_q;
    logic [CNT_W-1:0]         starve_cnt_d;
    logic                     ena_q;
    logic                     ena_d;
    logic [XLEN_P-1:0]        wdat_q;
    logic [XLEN_P-1:0]        wdat_d;
    logic [RFIDX_WIDTH_P-1:0] rdidx_q;
    logic [RFIDX_WIDTH_P-1:0] rdidx_d;

    logic      force_alu_s;
    logic      lsu_ready_s;
    logic      alu_ready_s;
    wbck_gnt_e gnt_src_s;

    // Grant: LSU first unless the ALU has waited STARVE_MAX LSU grants; nothing granted in reset.
    always_comb begin
        force_alu_s = (starve_cnt_q == STARVE_MAX_C);
        lsu_ready_s = rst & lsu_wbck_i_valid & ~(force_alu_s & alu_wbck_i_valid);
        alu_ready_s = rst & alu_wbck_i_valid & ~lsu_ready_s;
        if (lsu_ready_s) begin
            gnt_src_s = GNT_LSU;
        end else if (alu_ready_s) begin
            gnt_src_s = GNT_ALU;
        end else begin
            gnt_src_s = GNT_NONE;
        end
    end

    // Starvation counter: counts LSU grants that overtook a waiting ALU request.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (alu_ready_s || !alu_wbck_i_valid) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else if (lsu_ready_s) begin
            if (starve_cnt_q != STARVE_MAX_C) begin
                starve_cnt_d = starve_cnt_q + CNT_ONE_C;
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Output stage next state: load the granted payload, otherwise hold data and drop enable.
    always_comb begin
        ena_d   = 1'b0;
        wdat_d  = wdat_q;
        rdidx_d = rdidx_q;
        case (gnt_src_s)
            GNT_LSU: begin
                ena_d   = is_rf_write(lsu_wbck_i_rdidx);
                wdat_d  = lsu_wbck_i_wdat;
                rdidx_d = lsu_wbck_i_rdidx;
            end
            GNT_ALU: begin
                ena_d   = is_rf_write(alu_wbck_i_rdidx);
                wdat_d  = alu_wbck_i_wdat;
                rdidx_d = alu_wbck_i_rdidx;
            end
            default: begin
                ena_d   = 1'b0;
                wdat_d  = wdat_q;
                rdidx_d = rdidx_q;
            end
        endcase
    end

    // State registers; reset discards any write sitting in the output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= {CNT_W{1'b0}};
            ena_q        <= 1'b0;
            wdat_q       <= {XLEN_P{1'b0}};
            rdidx_q      <= {RFIDX_WIDTH_P{1'b0}};
        end else begin
            starve_cnt_q <= starve_cnt_d;
            ena_q        <= ena_d;
            wdat_q       <= wdat_d;
            rdidx_q      <= rdidx_d;
        end
    end

    // Drive ports; idle is forced high while reset is asserted.
    always_comb begin
        alu_wbck_i_ready = alu_ready_s;
        lsu_wbck_i_ready = lsu_ready_s;
        rf_wbck_o_ena    = ena_q;
        rf_wbck_o_wdat   = wdat_q;
        rf_wbck_o_rdidx  = rdidx_q;
        if (rst) begin
            wbck_idle = ~alu_wbck_i_valid & ~lsu_wbck_i_valid & ~ena_q;
        end else begin
            wbck_idle = 1'b1;
        end
    end

endmodule

// File: tb/tb_exu_wbck_arb.sv
// Directed bench for exu_wbck_arb with hand-computed expectations.
module tb_exu_wbck_arb;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [31:0] alu_wdat;
    logic [4:0]  alu_rdidx;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [31:0] lsu_wdat;
    logic [4:0]  lsu_rdidx;
    logic        ena;
    logic [31:0] wdat;
    logic [4:0]  rdidx;
    logic        idle;

    int n_checks = 0;
    int n_err    = 0;

    exu_wbck_arb #(.XLEN_P(32), .RFIDX_WIDTH_P(5), .STARVE_MAX(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .alu_wbck_i_valid (alu_valid),
        .alu_wbck_i_ready (alu_ready),
        .alu_wbck_i_wdat  (alu_wdat),
        .alu_wbck_i_rdidx (alu_rdidx),
        .lsu_wbck_i_valid (lsu_valid),
        .lsu_wbck_i_ready (lsu_ready),
        .lsu_wbck_i_wdat  (lsu_wdat),
        .lsu_wbck_i_rdidx (lsu_rdidx),
        .rf_wbck_o_ena    (ena),
        .rf_wbck_o_wdat   (wdat),
        .rf_wbck_o_rdidx  (rdidx),
        .wbck_idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                         input logic lv, input logic [4:0] li, input logic [31:0] ld);
        alu_valid = av; alu_rdidx = ai; alu_wdat = ad;
        lsu_valid = lv; lsu_rdidx = li; lsu_wdat = ld;
    endtask

    // Advance past the next rising edge so registered outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_l;
        logic [31:0] exp_cnt [10];
        exp_cnt = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};

        // Reset state
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #12;
        chk("rst_ena",   {31'd0, ena}, 32'd0);
        chk("rst_wdat",  wdat, 32'd0);
        chk("rst_idx",   {27'd0, rdidx}, 32'd0);
        chk("rst_idle",  {31'd0, idle}, 32'd1);
        chk("rst_cnt",   32'(dut.starve_cnt_q), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 1: ALU only, idx 5
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
        #1;
        chk("s1_alu_rdy", {31'd0, alu_ready}, 32'd1);
        chk("s1_lsu_rdy", {31'd0, lsu_ready}, 32'd0);
        chk("s1_idle",    {31'd0, idle}, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("s1_ena",  {31'd0, ena}, 32'd1);
        chk("s1_idx",  {27'd0, rdidx}, 32'd5);
        chk("s1_dat",  wdat, 32'h1234);
        tick();
        chk("s1_ena_off", {31'd0, ena}, 32'd0);
        chk("s1_idle2",   {31'd0, idle}, 32'd1);

        // 3: ALU write to x0 is accepted but not enabled
        drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0);
        #1;
        chk("s3_alu_rdy", {31'd0, alu_ready}, 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("s3_ena", {31'd0, ena}, 32'd0);
        chk("s3_idx", {27'd0, rdidx}, 32'd0);
        chk("s3_dat", wdat, 32'hFFFF);

        // 2: both valid continuously -> L,L,L,L,A,L,L,L,L,A
        drive(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd9, 32'h5555);
        for (int i = 0; i < 10; i++) begin
            exp_l = (i % 5) != 4;
            #1;
            chk("s2_lsu_rdy", {31'd0, lsu_ready}, {31'd0, exp_l});
            chk("s2_alu_rdy", {31'd0, alu_ready}, {31'd0, ~exp_l});
            tick();
            chk("s2_cnt", 32'(dut.starve_cnt_q), exp_cnt[i]);
            chk("s2_idx", {27'd0, rdidx}, exp_l ? 32'd9 : 32'd7);
            chk("s2_ena", {31'd0, ena}, 32'd1);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        // 4: LSU only, 6 back-to-back writes
        for (int i = 1; i <= 6; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 32'h100 + 32'(i));
            #1;
            chk("s4_lsu_rdy", {31'd0, lsu_ready}, 32'd1);
            tick();
            chk("s4_ena", {31'd0, ena}, 32'd1);
            chk("s4_idx", {27'd0, rdidx}, 32'(i));
            chk("s4_dat", wdat, 32'h100 + 32'(i));
            chk("s4_cnt", 32'(dut.starve_cnt_q), 32'd0);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("s4_ena_off", {31'd0, ena}, 32'd0);

        // 6: starve_cnt=2, ALU drops valid for one cycle -> counter clears
        drive(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd9, 32'h5555);
        tick();
        tick();
        chk("s6_cnt2", 32'(dut.starve_cnt_q), 32'd2);
        drive(1'b0, 5'd7, 32'hAAAA, 1'b1, 5'd10, 32'h6666);
        #1;
        chk("s6_lsu_rdy_a", {31'd0, lsu_ready}, 32'd1);
        tick();
        chk("s6_cnt0", 32'(dut.starve_cnt_q), 32'd0);
        drive(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd11, 32'h7777);
        #1;
        chk("s6_lsu_rdy_b", {31'd0, lsu_ready}, 32'd1);
        chk("s6_alu_rdy_b", {31'd0, alu_ready}, 32'd0);
        tick();
        chk("s6_cnt1", 32'(dut.starve_cnt_q), 32'd1);
        chk("s6_idx",  {27'd0, rdidx}, 32'd11);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        // 5: async reset mid-cycle while a write is in the output stage
        drive(1'b1, 5'd3, 32'hBEEF, 1'b0, 5'd0, 32'h0);
        tick();
        chk("s5_ena_pre", {31'd0, ena}, 32'd1);
        drive(1'b1, 5'd3, 32'hBEEF, 1'b1, 5'd4, 32'hCAFE);
        #2;
        rst = 1'b0;
        #1;
        chk("s5_ena",     {31'd0, ena}, 32'd0);
        chk("s5_idx",     {27'd0, rdidx}, 32'd0);
        chk("s5_dat",     wdat, 32'd0);
        chk("s5_alu_rdy", {31'd0, alu_ready}, 32'd0);
        chk("s5_lsu_rdy", {31'd0, lsu_ready}, 32'd0);
        chk("s5_idle",    {31'd0, idle}, 32'd1);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        tick();
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
        #1;
        chk("s5_post_rdy", {31'd0, alu_ready}, 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("s5_post_ena", {31'd0, ena}, 32'd1);
        chk("s5_post_idx", {27'd0, rdidx}, 32'd5);
        chk("s5_post_dat", wdat, 32'h1234);
        tick();
        chk("s5_post_off", {31'd0, ena}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
